stld_fwd_cache: RTL

- Parametrised store-to-load forwarding tag cache inside the Load-Store Unit, enabled by LEN5_STORE_LOAD_FWD_EN.
- Direct-mapped, doubleword-granular. For each cached line it records the store-buffer index of the youngest in-flight store to that doubleword.
- Load-buffer lookups get a same-cycle hit and a store-buffer index. The store buffer then attempts data forwarding.
- Successor of the fixed-size store-buffer mirror:
  - cache depth is decoupled from store-buffer depth;
  - memory-mapped region bypass is configurable;
  - adds a precise invalidate-by-index operation, a flush, and a hit counter for HPM CSRs.

---
 rtl/stld_fwd_cache.sv | 92 +++++++++
 1 files changed

// File: rtl/stld_fwd_cache.sv
// Direct-mapped store-to-load forwarding tag cache: tracks the youngest in-flight
// store per doubleword and answers load lookups in the same cycle.
module stld_fwd_cache #(
  parameter int unsigned           ADDR_W       = 64,
  parameter int unsigned           STBUFF_DEPTH = 16,
  parameter int unsigned           CACHE_DEPTH  = 16,
  parameter logic [ADDR_W-1:0]     MMAP_MASK    = 64'hffffffffe0000000,
  parameter int unsigned           HITCNT_W     = 64,
  localparam int unsigned          SB_IDX_W     = $clog2(STBUFF_DEPTH),
  localparam int unsigned          IDX_W        = $clog2(CACHE_DEPTH),
  localparam int unsigned          TAG_W        = ADDR_W - 3 - IDX_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                st_upd_valid_i,
  input  logic [ADDR_W-1:0]   st_upd_addr_i,
  input  logic [SB_IDX_W-1:0] st_upd_idx_i,
  input  logic                st_inv_valid_i,
  input  logic [SB_IDX_W-1:0] st_inv_idx_i,
  input  logic                ld_lookup_valid_i,
  input  logic [ADDR_W-1:0]   ld_lookup_addr_i,
  output logic                ld_hit_o,
  output logic [SB_IDX_W-1:0] ld_stbuff_idx_o,
  output logic [HITCNT_W-1:0] hit_cnt_o
);

  logic [CACHE_DEPTH-1:0] valid_q, valid_d, eff_valid;
  logic [TAG_W-1:0]       tag_q   [CACHE_DEPTH];
  logic [TAG_W-1:0]       tag_d   [CACHE_DEPTH];
  logic [SB_IDX_W-1:0]    sbidx_q [CACHE_DEPTH];
  logic [SB_IDX_W-1:0]    sbidx_d [CACHE_DEPTH];
  logic [HITCNT_W-1:0]    hit_cnt_q, hit_cnt_d;

  logic             upd_ok;
  logic [IDX_W-1:0] upd_line, ld_line;
  logic [TAG_W-1:0] upd_tag, ld_tag;
  logic             ld_cacheable;
  logic             hit;

  assign upd_ok       = st_upd_valid_i && ((st_upd_addr_i & MMAP_MASK) == '0);
  assign upd_line     = st_upd_addr_i[3+IDX_W-1:3];
  assign upd_tag      = st_upd_addr_i[ADDR_W-1:3+IDX_W];
  assign ld_line      = ld_lookup_addr_i[3+IDX_W-1:3];
  assign ld_tag       = ld_lookup_addr_i[ADDR_W-1:3+IDX_W];
  assign ld_cacheable = (ld_lookup_addr_i & MMAP_MASK) == '0;

  // Effective state: invalidate first, then the update overrides its own line.
  always_comb begin
    eff_valid = '0;
    for (int i = 0; i < CACHE_DEPTH; i++) begin
      eff_valid[i] = valid_q[i] && !(st_inv_valid_i && (sbidx_q[i] == st_inv_idx_i));
      tag_d[i]     = tag_q[i];
      sbidx_d[i]   = sbidx_q[i];
      if (upd_ok && (upd_line == IDX_W'(i))) begin
        eff_valid[i] = 1'b1;
        tag_d[i]     = upd_tag;
        sbidx_d[i]   = st_upd_idx_i;
      end
    end
    valid_d = flush_i ? '0 : eff_valid;
  end

  always_comb begin
    hit             = rst_ni && ld_lookup_valid_i && ld_cacheable &&
                      eff_valid[ld_line] && (tag_d[ld_line] == ld_tag);
    ld_hit_o        = hit;
    ld_stbuff_idx_o = hit ? sbidx_d[ld_line] : '0;
    hit_cnt_d       = hit_cnt_q + HITCNT_W'(hit);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q   <= '0;
      hit_cnt_q <= '0;
      for (int i = 0; i < CACHE_DEPTH; i++) begin
        tag_q[i]   <= '0;
        sbidx_q[i] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      hit_cnt_q <= hit_cnt_d;
      for (int i = 0; i < CACHE_DEPTH; i++) begin
        tag_q[i]   <= tag_d[i];
        sbidx_q[i] <= sbidx_d[i];
      end
    end
  end

  assign hit_cnt_o = hit_cnt_q;

endmodule
